// File: rtl/div_nr_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_nr_param                                                               |
// | Sequential non-restoring divider, one quotient bit per clock, start/done.  |
// | Optional signed mode is compiled in when DIV_SIGNED_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH:0]   acc;        // partial remainder A, two's complement
  logic [WIDTH-1:0] quo;        // quotient shift register Q
  logic [WIDTH-1:0] dsr;        // divisor magnitude M
  logic [CNT_W-1:0] iter_cnt;
  logic             zero_flag;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  logic [WIDTH:0]   acc_shift;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept       = (state == S_IDLE) && start;
  assign divisor_zero = (divisor == '0);

  // One non-restoring step: shift {A,Q}, then subtract or add M by the old sign of A.
  assign acc_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
  assign acc_step  = acc[WIDTH] ? (acc_shift + {1'b0, dsr})
                                : (acc_shift - {1'b0, dsr});

  // Final correction of a negative remainder; the true value lies in [0, M).
  assign rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + dsr) : acc[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sgn_q_in;
  logic sgn_r_in;

  assign sgn_r_in = is_signed & dividend[WIDTH-1];
  assign sgn_q_in = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  // Negating MIN yields 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign dvd_mag  = sgn_r_in ? (-dividend) : dividend;
  assign dsr_mag  = (is_signed & divisor[WIDTH-1]) ? (-divisor) : divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sgn_q_in;
      neg_r <= sgn_r_in;
    end
  end

  assign q_fix = neg_q ? (-quo) : quo;
  assign r_fix = (neg_r && (rem_mag != '0)) ? (-rem_mag) : rem_mag;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag          = dividend;
  assign dsr_mag          = divisor;
  assign q_fix            = quo;
  assign r_fix            = rem_mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = divisor_zero ? S_FIX : S_ITER;
        end
      end
      S_ITER: begin
        busy = 1'b1;
        if (iter_cnt == LAST_ITER) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      quo         <= '0;
      dsr         <= '0;
      iter_cnt    <= '0;
      zero_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      acc       <= '0;
      iter_cnt  <= '0;
      dsr       <= dsr_mag;
      zero_flag <= divisor_zero;
      // With a zero divisor Q carries the untouched dividend straight to FIX.
      quo       <= divisor_zero ? dividend : dvd_mag;
    end else begin
      case (state)
        S_ITER: begin
          acc      <= acc_step;
          quo      <= {quo[WIDTH-2:0], ~acc_step[WIDTH]};
          iter_cnt <= iter_cnt + 1'b1;
        end
        S_FIX: begin
          if (zero_flag) begin
            quotient    <= '1;
            remainder   <= quo;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_nr_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_nr_param                                                            |
// | Self-checking bench for div_nr_param at WIDTH=32 and WIDTH=8.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_div_nr_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st32, sg32, busy32, done32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic        st8, sg8, busy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;

  div_nr_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(st32), .dividend(a32), .divisor(b32),
    .is_signed(sg32), .busy(busy32), .done(done32), .quotient(q32),
    .remainder(r32), .div_by_zero(dz32)
  );

  div_nr_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .dividend(a8), .divisor(b8),
    .is_signed(sg8), .busy(busy8), .done(done8), .quotient(q8),
    .remainder(r8), .div_by_zero(dz8)
  );

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } res_t;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        z;
  } vec_t;

  res_t        sb32[$];
  res_t        exp32;
  vec_t        vecs[16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ra, rb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every done pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done32) begin
      if (sb32.size() == 0) begin
        check("unexpected_done32", {31'b0, done32}, 32'd0);
      end else begin
        exp32 = sb32.pop_front();
        check("quotient32", q32, exp32.q);
        check("remainder32", r32, exp32.r);
        check("div_by_zero32", {31'b0, dz32}, {31'b0, exp32.z});
      end
    end
  end

  task automatic run32(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input bit hold, input string tag);
    int lat;
    @(negedge clk);
    a32  = dvd;
    b32  = dvs;
    sg32 = sgn;
    st32 = 1'b1;
    sb32.push_back('{eq, er, ez});
    @(posedge clk); #1;
    check({tag, "_busy"}, {31'b0, busy32}, 32'd1);
    if (!hold) st32 = 1'b0;
    a32  = ~dvd;
    b32  = dvs ^ 32'h5;
    sg32 = ~sgn;
    lat  = 0;
    while (!done32 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), (dvs == 32'd0) ? 32'd1 : 32'd33);
    check({tag, "_busy_at_done"}, {31'b0, busy32}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, {31'b0, done32}, 32'd0);
    st32 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_no_accept"}, {31'b0, busy32}, 32'd0);
    check({tag, "_q_held"}, q32, eq);
    check({tag, "_r_held"}, r32, er);
  endtask

  task automatic run8(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                      input logic [7:0] eq, input logic [7:0] er, input string tag);
    int lat;
    @(negedge clk);
    a8  = dvd;
    b8  = dvs;
    sg8 = sgn;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    a8  = ~dvd;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_q"}, {24'b0, q8}, {24'b0, eq});
    check({tag, "_r"}, {24'b0, r8}, {24'b0, er});
    check({tag, "_z"}, {31'b0, dz8}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, {31'b0, done8}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            dividend      divisor       sgn   q signed      r signed      q unsigned    r unsigned    z
    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1,        1'b0};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        32'd0,        32'd7,        1'b0};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        32'd0,        32'h80000000, 1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 32'd0,        32'h80000000, 1'b0};
    vecs[5]  = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     32'hFFFFFFFF, 32'h1234,     1'b1};
    vecs[6]  = '{32'd50,       32'd5,        1'b0, 32'd10,       32'd0,        32'd10,       32'd0,        1'b0};
    vecs[7]  = '{32'hFFFFFF00, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b1};
    vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 32'd0,        32'hFFFFFF9C, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[10] = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        32'd0,        32'd5,        1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        32'd1,        32'd0,        1'b0};
    vecs[12] = '{32'd123456789, 32'd1000,    1'b0, 32'd123456,   32'd789,      32'd123456,   32'd789,      1'b0};
    vecs[13] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        32'h80000000, 32'd0,        1'b0};
    vecs[14] = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        32'd0,        32'd100,      1'b0};
    vecs[15] = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b0};

    reset = 1'b1;
    st32  = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    st8   = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy32}, 32'd0);
    check("reset_done", {31'b0, done32}, 32'd0);
    check("reset_quotient", q32, 32'd0);
    check("reset_remainder", r32, 32'd0);
    check("reset_dbz", {31'b0, dz32}, 32'd0);
    check("reset_q8", {24'b0, q8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run32(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn,
            (vecs[i].sgn && SIGNED_BUILD) ? vecs[i].q_s : vecs[i].q_u,
            (vecs[i].sgn && SIGNED_BUILD) ? vecs[i].r_s : vecs[i].r_u,
            vecs[i].z, 1'b0, $sformatf("vec%0d", i));
    end

    // start held high for the whole operation and its done cycle
    run32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, "hold");

    // reset lands after ten iterations of a fresh divide
    @(negedge clk);
    a32 = 32'd999; b32 = 32'd13; sg32 = 1'b0; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", {31'b0, busy32}, 32'd0);
    check("midreset_done", {31'b0, done32}, 32'd0);
    check("midreset_quotient", q32, 32'd0);
    check("midreset_remainder", r32, 32'd0);
    check("midreset_dbz", {31'b0, dz32}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_idle", {31'b0, busy32}, 32'd0);
    run32(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 65535)) : ($urandom | 32'd1);
      run32(ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    run8(8'd200, 8'd3, 1'b0, 8'd66, 8'd2, "w8_200_3");
    run8(8'd255, 8'd255, 1'b0, 8'd1, 8'd0, "w8_255_255");
    run8(8'h80, 8'hFF, 1'b1, SIGNED_BUILD ? 8'h80 : 8'h00,
         SIGNED_BUILD ? 8'h00 : 8'h80, "w8_min_m1");

    repeat (2) @(posedge clk);
    #1;
    check("sb32_empty", 32'(sb32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_nr_param.md
# div_nr_param

Parametrised sequential non-restoring divider with a start/done handshake, optional signed mode and divide-by-zero detection. It is the next-generation replacement for the fixed 32-bit divider in the ALU datapath. The control unit issues one operation at a time through it for DIV/REM instructions. It processes one quotient bit per clock and holds results stable until the next accepted start.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  numerator, latched on accepted start
- divisor  in  WIDTH  denominator, latched on accepted start
- is_signed  in  1  two's-complement operation when 1, latched on accepted start
- busy  out  1  high from the edge after an accepted start until the edge that asserts done
- done  out  1  single-cycle pulse, results valid
- quotient  out  WIDTH  result quotient, held until the next accepted start
- remainder  out  WIDTH  result remainder, held until the next accepted start
- div_by_zero  out  1  set with done when divisor == 0, held with results

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1: latch operands and mode, then go to ITER; busy=1.
  - In signed mode, take magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values. |MIN| = 2^(WIDTH-1).
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- IDLE, start=1, divisor == 0: go directly to FIX with the zero flag set. ITER is skipped.
- ITER: WIDTH iterations, one per edge. The partial remainder A is WIDTH+1 bits, signed.
  - Shift {A,Q} left by 1.
  - If A ≥ 0 before the shift, A = A − M; otherwise A = A + M.
  - Q[0] = ~A[WIDTH].
  - An iteration counter runs 0..WIDTH−1; after the last iteration go to FIX.
- FIX, one edge:
  - If A < 0, A = A + M.
  - In signed mode, negate Q if sign_q, and negate A if sign_r and A ≠ 0.
  - Register quotient and remainder, then go to DONE.
- FIX with the zero flag: quotient = all ones, remainder = original dividend (unmodified, either mode), div_by_zero = 1.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Overflow, signed MIN / −1: quotient = MIN (wraps), remainder = 0, no flag.
- start while busy or in DONE is ignored. It is not queued.
- reset at any time, including mid-ITER: next state IDLE; busy, done, quotient, remainder, div_by_zero all 0; the counter is cleared.

## Timing
- Reset values: busy 0, done 0, quotient 0, remainder 0, div_by_zero 0.
- Start accepted at edge E0:
  - busy is high after E0.
  - Iterations occur at E1..E_WIDTH.
  - FIX occurs at E_WIDTH+1.
  - done is high after E_WIDTH+1, and busy falls at the same edge.
- Normal latency: WIDTH+1 edges from the accepting edge to the done pulse (33 for WIDTH=32).
- Divide-by-zero latency: FIX at E1, done high after E1.
- Earliest next accept: start sampled at the edge ending the done cycle. That edge moves DONE→IDLE and does not accept; the start must be presented in IDLE.
- Output timing: outputs change only at the FIX edge or on reset. They are stable through done and afterwards.
- Operand changes: changes on dividend/divisor/is_signed after E0 have no effect.

## Configuration
- `DIV_SIGNED_EN` defined: is_signed is honoured as described, including the magnitude, sign-fix and MIN/−1 logic.
- `DIV_SIGNED_EN` undefined: the signed logic is compiled out. is_signed is present but ignored, and all operations are unsigned. Latency is unchanged.

## Test plan
- Unsigned, WIDTH=32, 100 / 7 → quotient 14, remainder 2, div_by_zero 0; done exactly 33 edges after the accepting edge, one cycle wide.
- Signed (`DIV_SIGNED_EN`), −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- 0x80000000 / 0xFFFFFFFF: signed → quotient 0x80000000, remainder 0; unsigned → quotient 0, remainder 0x80000000.
- 0x1234 / 0 → quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1; done one edge after acceptance; the next valid divide clears div_by_zero.
- Reset and start handling:
  - Assert reset at iteration 10 → all outputs 0 next cycle, state IDLE.
  - A new start of 50 / 5 afterwards → quotient 10, remainder 0.
  - start pulses held during busy → no effect on the result or on done timing.
- WIDTH=8 instance: 200 / 3 unsigned → quotient 66, remainder 2; done 9 edges after acceptance.
